// File: rtl/rca_wb_commit_pkg.sv
// Shared types and constants for the RCA writeback commit path.
package rca_wb_commit_pkg;

    localparam int NUM_WRITE_PORTS = 5;
    localparam int RF_WR_PORTS     = 2;
    localparam int BUF_DEPTH       = 2;
    localparam int XLEN            = 32;
    localparam int ID_W            = 3;
    localparam int LANE_W          = $clog2(NUM_WRITE_PORTS);

    typedef logic [ID_W-1:0] id_t;

    // One buffered writeback: id, per-lane data and destination, and the
    // lanes that still need a register-file write.
    typedef struct packed {
        id_t                                    id;
        logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]   rd;
        logic [NUM_WRITE_PORTS-1:0][4:0]        addr;
        logic [NUM_WRITE_PORTS-1:0]             mask;
    } rca_wb_entry_t;

    // State of the current FIFO head.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_RETIRE
    } wb_state_t;

    // Lanes that carry a result to a real register; writes to x0 are dropped.
    function automatic logic [NUM_WRITE_PORTS-1:0] eff_mask(
        input logic [NUM_WRITE_PORTS-1:0]      valid,
        input logic [NUM_WRITE_PORTS-1:0][4:0] addr
    );
        logic [NUM_WRITE_PORTS-1:0] m;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            m[i] = valid[i] && (addr[i] != 5'd0);
        end
        return m;
    endfunction

endpackage

// File: rtl/rca_wb_lane_select.sv
// Picks the lowest-index pending lanes for this cycle's write ports and
// suppresses the lower lane of any same-address pair in the batch.
module rca_wb_lane_select
    import rca_wb_commit_pkg::*;
(
    input  logic [NUM_WRITE_PORTS-1:0]             pending,
    input  logic [NUM_WRITE_PORTS-1:0][4:0]        addr,
    output logic [RF_WR_PORTS-1:0][LANE_W-1:0]     port_lane,
    output logic [RF_WR_PORTS-1:0]                 port_we,
    output logic [NUM_WRITE_PORTS-1:0]             cleared
);

    logic [NUM_WRITE_PORTS-1:0] rem;
    logic [RF_WR_PORTS-1:0]     sel;
    logic                       found;

    // Priority pick per port, then drop lower lanes shadowed by a higher lane.
    always_comb begin
        rem       = pending;
        sel       = '0;
        port_lane = '0;
        cleared   = '0;
        found     = 1'b0;
        for (int k = 0; k < RF_WR_PORTS; k++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                if (!found && rem[i]) begin
                    found        = 1'b1;
                    sel[k]       = 1'b1;
                    port_lane[k] = LANE_W'(i);
                    rem[i]       = 1'b0;
                    cleared[i]   = 1'b1;
                end
            end
        end
        port_we = sel;
        for (int k = 0; k < RF_WR_PORTS; k++) begin
            for (int j = k + 1; j < RF_WR_PORTS; j++) begin
                if (sel[k] && sel[j] && (addr[port_lane[k]] == addr[port_lane[j]])) begin
                    port_we[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rca_wb_commit.sv
// Buffers RCA writebacks and drains them into the register file, retiring
// each instruction in the cycle of its last write batch.
module rca_wb_commit
    import rca_wb_commit_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   rca_done,
    input  id_t                                    rca_id,
    input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]   rca_rd,
    input  logic [NUM_WRITE_PORTS-1:0][4:0]        rca_dest_addr,
    input  logic [NUM_WRITE_PORTS-1:0]             rca_dest_valid,
    output logic                                   rca_ready,
    output logic [RF_WR_PORTS-1:0]                 rf_we,
    output logic [RF_WR_PORTS-1:0][4:0]            rf_waddr,
    output logic [RF_WR_PORTS-1:0][XLEN-1:0]       rf_wdata,
    output logic                                   retire_valid,
    output id_t                                    retire_id,
    output logic                                   overflow_err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    rca_wb_entry_t                          mem [BUF_DEPTH];
    rca_wb_entry_t                          head;
    rca_wb_entry_t                          next_head;
    logic [PTR_W-1:0]                       rd_ptr;
    logic [PTR_W-1:0]                       wr_ptr;
    logic [CNT_W-1:0]                       count;
    logic [NUM_WRITE_PORTS-1:0]             pending;
    logic [NUM_WRITE_PORTS-1:0]             in_mask;
    logic [NUM_WRITE_PORTS-1:0]             cleared;
    logic [NUM_WRITE_PORTS-1:0]             remaining;
    logic [NUM_WRITE_PORTS-1:0]             pend_next;
    logic [RF_WR_PORTS-1:0][LANE_W-1:0]     port_lane;
    logic [RF_WR_PORTS-1:0]                 port_we;
    wb_state_t                              state;
    logic                                   drain;
    logic                                   push;
    logic                                   pop;
    logic                                   head_next;

    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + 1'b1];
    assign in_mask   = eff_mask(rca_dest_valid, rca_dest_addr);
    assign rca_ready = (count < CNT_W'(BUF_DEPTH));
    assign push      = rca_done && rca_ready && !flush;
    assign drain     = (state == ST_DRAIN) && !flush;
    assign remaining = pending & ~cleared;

    assign retire_valid = !flush && ((state == ST_RETIRE) ||
                                     ((state == ST_DRAIN) && (remaining == '0)));
    assign retire_id    = retire_valid ? head.id : '0;
    assign pop          = retire_valid;

    rca_wb_lane_select u_lane_select (
        .pending   (pending),
        .addr      (head.addr),
        .port_lane (port_lane),
        .port_we   (port_we),
        .cleared   (cleared)
    );

    // Register-file ports follow the selected lanes of the head entry.
    always_comb begin
        rf_we    = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        for (int k = 0; k < RF_WR_PORTS; k++) begin
            if (drain && port_we[k]) begin
                rf_we[k]    = 1'b1;
                rf_waddr[k] = head.addr[port_lane[k]];
                rf_wdata[k] = head.rd[port_lane[k]];
            end
        end
    end

    // Work out which entry is head next cycle and what it still has to write.
    always_comb begin
        head_next = 1'b0;
        pend_next = '0;
        if (pop) begin
            if (count > CNT_W'(1)) begin
                head_next = 1'b1;
                pend_next = next_head.mask;
            end else if (push) begin
                head_next = 1'b1;
                pend_next = in_mask;
            end
        end else if (count == '0) begin
            head_next = push;
            pend_next = push ? in_mask : '0;
        end else begin
            head_next = 1'b1;
            pend_next = drain ? remaining : pending;
        end
    end

    // Entry storage; only control state needs a reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{id: rca_id, rd: rca_rd, addr: rca_dest_addr, mask: in_mask};
        end
    end

    // FIFO pointers, head FSM, pending lanes and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            pending      <= '0;
            state        <= ST_IDLE;
            overflow_err <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pending <= '0;
            state   <= ST_IDLE;
        end else begin
            if (rca_done && !rca_ready) begin
                overflow_err <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            pending <= pend_next;
            if (!head_next) begin
                state <= ST_IDLE;
            end else if (pend_next != '0) begin
                state <= ST_DRAIN;
            end else begin
                state <= ST_RETIRE;
            end
        end
    end

endmodule

// File: tb/tb_rca_wb_commit.sv
// Randomized bench for rca_wb_commit against a queue-based reference model.
module tb_rca_wb_commit;

    localparam int NL = 5;
    localparam int RF = 2;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [2:0]             id;
        logic [NL-1:0][31:0]    rd;
        logic [NL-1:0][4:0]     addr;
        logic [NL-1:0]          mask;
    } ent_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       rca_done;
    logic [2:0]                 rca_id;
    logic [NL-1:0][31:0]        rca_rd;
    logic [NL-1:0][4:0]         rca_dest_addr;
    logic [NL-1:0]              rca_dest_valid;
    logic                       rca_ready;
    logic [RF-1:0]              rf_we;
    logic [RF-1:0][4:0]         rf_waddr;
    logic [RF-1:0][31:0]        rf_wdata;
    logic                       retire_valid;
    logic [2:0]                 retire_id;
    logic                       overflow_err;

    int checks = 0;
    int failures = 0;

    ent_t q[$];
    int   bidx = 0;
    logic ov = 1'b0;

    always #5 clk = ~clk;

    rca_wb_commit dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .rca_done       (rca_done),
        .rca_id         (rca_id),
        .rca_rd         (rca_rd),
        .rca_dest_addr  (rca_dest_addr),
        .rca_dest_valid (rca_dest_valid),
        .rca_ready      (rca_ready),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .retire_valid   (retire_valid),
        .retire_id      (retire_id),
        .overflow_err   (overflow_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0;
        flush = 1'b0;
        rca_done = 1'b0;
        rca_id = '0;
        rca_rd = '0;
        rca_dest_addr = '0;
        rca_dest_valid = '0;
    endtask

    // Five valid lanes, x1..x5, data 0xA0..0xA4.
    task automatic set_full(input logic [2:0] id);
        set_idle();
        rca_done = 1'b1;
        rca_id = id;
        rca_dest_valid = 5'b11111;
        for (int i = 0; i < NL; i++) begin
            rca_dest_addr[i] = 5'(i + 1);
            rca_rd[i] = 32'hA0 + 32'(i);
        end
    endtask

    // Check this cycle's outputs against the model, then advance the model across the edge.
    task automatic tick();
        logic [RF-1:0]          ewe;
        logic [RF-1:0][4:0]     ewa;
        logic [RF-1:0][31:0]    ewd;
        logic                   eret;
        logic [2:0]             eid;
        logic                   eready;
        logic                   do_push;
        int                     lanes[$];
        int                     nb;
        int                     idx;
        ent_t                   h;
        ent_t                   ne;
        @(negedge clk);
        ewe = '0; ewa = '0; ewd = '0; eret = 1'b0; eid = '0;
        eready = (q.size() < DEPTH);
        if (!flush && q.size() > 0) begin
            h = q[0];
            for (int i = 0; i < NL; i++) if (h.mask[i]) lanes.push_back(i);
            nb = (lanes.size() + RF - 1) / RF;
            if (nb == 0) begin
                eret = 1'b1;
            end else begin
                for (int k = 0; k < RF; k++) begin
                    idx = bidx * RF + k;
                    if (idx < lanes.size()) begin
                        ewe[k] = 1'b1;
                        ewa[k] = h.addr[lanes[idx]];
                        ewd[k] = h.rd[lanes[idx]];
                    end
                end
                for (int k = 0; k < RF; k++) begin
                    for (int j = k + 1; j < RF; j++) begin
                        if (ewe[k] && ewe[j] && ewa[k] == ewa[j]) begin
                            ewe[k] = 1'b0; ewa[k] = '0; ewd[k] = '0;
                        end
                    end
                end
                eret = (bidx == nb - 1);
            end
            if (eret) eid = h.id;
        end
        chk("rca_ready", 64'(rca_ready), 64'(eready));
        chk("rf_we", 64'(rf_we), 64'(ewe));
        chk("rf_waddr", 64'(rf_waddr), 64'(ewa));
        chk("rf_wdata", 64'(rf_wdata), 64'(ewd));
        chk("retire_valid", 64'(retire_valid), 64'(eret));
        chk("retire_id", 64'(retire_id), 64'(eid));
        chk("overflow_err", 64'(overflow_err), 64'(ov));
        do_push = rca_done && !flush && (q.size() < DEPTH);
        if (rst) begin
            q.delete(); bidx = 0; ov = 1'b0;
        end else if (flush) begin
            q.delete(); bidx = 0;
        end else begin
            if (rca_done && q.size() >= DEPTH) ov = 1'b1;
            if (eret) begin
                void'(q.pop_front()); bidx = 0;
            end else if (q.size() > 0) begin
                bidx++;
            end
            if (do_push) begin
                ne.id = rca_id;
                ne.rd = rca_rd;
                ne.addr = rca_dest_addr;
                for (int i = 0; i < NL; i++) ne.mask[i] = rca_dest_valid[i] && (rca_dest_addr[i] != 0);
                q.push_back(ne);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        set_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_ticks(2);

        // Five-lane drain over three cycles.
        set_full(3'd5);
        tick();
        idle_ticks(5);

        // Config writeback with no results.
        set_idle();
        rca_done = 1'b1; rca_id = 3'd3;
        tick();
        idle_ticks(2);

        // Lanes 1 and 3 collide on x7.
        set_idle();
        rca_done = 1'b1; rca_id = 3'd2;
        rca_dest_valid = 5'b01010;
        rca_dest_addr[1] = 5'd7; rca_rd[1] = 32'h11;
        rca_dest_addr[3] = 5'd7; rca_rd[3] = 32'h33;
        tick();
        idle_ticks(3);

        // Three back-to-back pulses into a two-deep buffer.
        for (int n = 0; n < 3; n++) begin
            set_full(3'(n + 1));
            tick();
        end
        idle_ticks(8);

        // Lane writing x0 is dropped.
        set_idle();
        rca_done = 1'b1; rca_id = 3'd6;
        rca_dest_valid = 5'b00011;
        rca_dest_addr[0] = 5'd0; rca_rd[0] = 32'hDEAD;
        rca_dest_addr[1] = 5'd9; rca_rd[1] = 32'h99;
        tick();
        idle_ticks(3);

        // Flush during the second drain cycle.
        set_full(3'd7);
        tick();
        idle_ticks(1);
        flush = 1'b1;
        tick();
        idle_ticks(3);

        // Reset mid-drain.
        set_full(3'd4);
        tick();
        idle_ticks(1);
        rst = 1'b1;
        tick();
        idle_ticks(3);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            set_idle();
            rca_done = ($urandom_range(0, 99) < 45);
            rca_id = 3'($urandom);
            rca_dest_valid = 5'($urandom);
            for (int i = 0; i < NL; i++) begin
                rca_rd[i] = $urandom;
                rca_dest_addr[i] = 5'($urandom_range(0, 7));
            end
            flush = ($urandom_range(0, 99) < 4);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle_ticks(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_wb_commit.md
Name: rca_wb_commit

Overview:
- CPU-side consumer of the RCA writeback interface.
- Accepts completed RCA results: an id plus up to NUM_WRITE_PORTS result words, each with a destination register address and a valid bit.
- Buffers them in a small FIFO and drains each entry into the register file through RF_WR_PORTS physical write ports, then signals instruction retirement.
- Sits between the RCA unit's writeback outputs and the register file / retire logic.

Parameters:
- NUM_WRITE_PORTS, 5, result lanes per RCA writeback.
- RF_WR_PORTS, 2, register-file write ports available per cycle (1..NUM_WRITE_PORTS).
- BUF_DEPTH, 2, writeback entries buffered (power of 2, >=2).
- XLEN, 32, data width.
- ID_W, 3, instruction id width (id_t).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered entries
- rca_done  in  1  one-cycle writeback pulse from RCA unit
- rca_id  in  ID_W  id of completing instruction
- rca_rd  in  NUM_WRITE_PORTS x XLEN  result words
- rca_dest_addr  in  NUM_WRITE_PORTS x 5  destination register per lane
- rca_dest_valid  in  NUM_WRITE_PORTS  lane carries a result
- rca_ready  out  1  buffer can accept rca_done this cycle
- rf_we  out  RF_WR_PORTS  register-file write enables
- rf_waddr  out  RF_WR_PORTS x 5  write addresses
- rf_wdata  out  RF_WR_PORTS x XLEN  write data
- retire_valid  out  1  one-cycle pulse: entry fully committed
- retire_id  out  ID_W  id being retired
- overflow_err  out  1  sticky: rca_done received while not ready

Behaviour:
- Reset values: rca_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, retire_valid=0, retire_id=0, overflow_err=0. FIFO is empty; pending mask is 0.
- rca_ready = (count < BUF_DEPTH). It is combinational from registered count and does not look ahead to a same-cycle pop.
- Push: on rca_done && rca_ready, capture id, rd, addr, and effective mask = rca_dest_valid & (addr != 0). Lanes writing x0 are dropped.
- rca_done && !rca_ready sets overflow_err (sticky until rst). The entry is dropped.
- Head pending mask loads from the entry mask when the entry becomes head. The earliest head is the cycle after push.
- FSM states:
  - IDLE: FIFO empty, or head just popped.
  - DRAIN: head valid and pending != 0.
  - RETIRE: head valid and pending == 0.
  - Transitions are evaluated every cycle on head state.
- Drain cycle:
  - Select the RF_WR_PORTS lowest-index pending lanes.
  - Port k drives the k-th selected lane: rf_we[k]=1, with addr and data.
  - Clear those lanes from pending.
  - rf_* outputs are combinational from head and pending.
- Same-address collision within one cycle: the higher-index lane wins; the lower lane's rf_we is suppressed and it counts as written. Across cycles, ascending lane order gives the same last-writer-wins result.
- Retire:
  - Fires in the same cycle as the final write batch, or in the first head cycle if the mask is 0 (config instructions).
  - retire_valid=1, retire_id=head id. Pop the head; the next entry becomes head next cycle.
- Latency from push: ceil(popcount(mask)/RF_WR_PORTS) cycles starting at push+1. Minimum is 1 cycle (retire at push+1).
- Push and pop in the same cycle are allowed; count is unchanged. A push when full is not rescued by a same-cycle pop.
- FIFO pointers wrap modulo BUF_DEPTH.
- Flush (highest priority after rst):
  - Empties the FIFO and clears pending. Outputs that cycle are rf_we=0 and retire_valid=0.
  - Writes already performed are not undone.
  - A simultaneous rca_done is discarded and does not set overflow_err.
- rst mid-drain: everything returns to reset values next cycle. Partial writes remain in the register file.

Decomposition:
- Shared package: rca_wb_entry_t {id_t id; logic [XLEN-1:0] rd[NUM_WRITE_PORTS]; logic [4:0] addr[NUM_WRITE_PORTS]; logic [NUM_WRITE_PORTS-1:0] mask;}. NUM_WRITE_PORTS and RF_WR_PORTS constants also go there.
- Sub-module rca_wb_lane_select: combinational priority selection of the first RF_WR_PORTS set bits of pending, plus collision suppression. Outputs per-port lane index/valid and the cleared-lane mask.

Test Plan:
- Lanes 0..4 valid, addrs 1..5, data 0xA0..0xA4, RF_WR_PORTS=2, push at cycle 0 →
  - c1: writes x1, x2
  - c2: writes x3, x4
  - c3: writes x5, retire_valid=1, retire_id=id.
- Config writeback with rca_dest_valid=0, id=3 → c1: retire_valid, retire_id=3, no rf_we.
- Lanes 1 and 3 both addr 7 (data 0x11, 0x33), other lanes invalid → one cycle with only x7=0x33 written, then retire.
- Three back-to-back rca_done pulses of 5-lane entries (BUF_DEPTH=2) → third sees rca_ready=0, overflow_err=1, only two retires.
- Lane addr 0 valid with data 0xDEAD → never written; retire at the expected cycle.
- Flush during c2 of the 5-lane case → no further writes or retire; x1, x2 stay written; rca_ready=1 next cycle.
